vga_write_arbiter: RTL and testbench
====================================

VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, per-source buffer entries; power of two, minimum 2.
REQ-002 Parameter CNT_W, default 16, width of each grant counter.
REQ-003 clk  input  1  pixel clock, shared with the VGA display RAM.
REQ-004 rst  input  1  reset; synchronous, active-high; clock clk.
REQ-005 reg_valid  input  1  register-file write update offered.
REQ-006 reg_addr  input  5  register index.
REQ-007 reg_data  input  32  register value.
REQ-008 reg_ready  output  1  register FIFO not full.
REQ-009 instr_valid / instr_addr[31:0] / instr_data[31:0]  input  instruction-memory update.
REQ-010 instr_ready  output  1  instruction FIFO not full.
REQ-011 data_valid / data_addr[31:0] / data_data[31:0]  input  data-memory update.
REQ-012 data_ready  output  1  data FIFO not full.
REQ-013 wr_valid  output  1  granted write presented to the display RAM.
REQ-014 wr_src  output  2  source of the granted write: 0 reg, 1 instr, 2 data.
REQ-015 wr_addr  output  32  granted address; reg_addr is zero-extended.
REQ-016 wr_data  output  32  granted data.
REQ-017 wr_ready  input  1  display RAM accepts the write.
REQ-018 grant_cnt_reg / grant_cnt_instr / grant_cnt_data  output  CNT_W each  completed-write counts.

Function
REQ-019 Push into a source FIFO occurs in any cycle where x_valid && x_ready.
REQ-020 x_ready = !full; a full FIFO never accepts a push, even in a cycle where it pops.
REQ-021 Two-state FSM: IDLE (wr_valid=0) and HOLD (wr_valid=1).
REQ-022 In IDLE, if any FIFO is non-empty: pop the round-robin winner, load wr_src/wr_addr/wr_data, and enter HOLD next cycle.
REQ-023 Round-robin order is reg, instr, data. Search starts at rr_ptr; a granted source sets rr_ptr to (source+1) mod 3.
REQ-024 In HOLD, wr_src/wr_addr/wr_data stay stable until wr_valid && wr_ready.
REQ-025 On a handshake, if any FIFO is non-empty: load the next winner in the same cycle and remain in HOLD (back-to-back, one write per cycle). Otherwise return to IDLE.
REQ-026 Latency: push in cycle N into an empty system gives wr_valid=1 in cycle N+2.
REQ-027 A source stays in its FIFO until granted; starvation is bounded to 2 grants of other sources.
REQ-028 Per-source ordering is FIFO. Cross-source ordering is not preserved.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

Reset
REQ-030 On rst: all FIFOs empty, FSM in IDLE, wr_valid=0, wr_src=0, wr_addr=0, wr_data=0, rr_ptr=reg, counters 0.
REQ-031 x_ready=1 during and after reset. rst asserted in HOLD drops the pending write and all buffered entries.

Configuration
REQ-032 Macro VGA_ARB_STATS_EN defined: each grant_cnt_x increments by 1 on every handshake from source x and saturates at all-ones.
REQ-033 Macro VGA_ARB_STATS_EN undefined: grant counters are tied to 0 and no counter flops are generated. Ports remain present.

Structure
REQ-034 Package vga_arb_pkg holds:
- enum src_e (SRC_REG=0, SRC_INSTR=1, SRC_DATA=2);
- struct wr_req_t {addr[31:0], data[31:0]};
- constant NUM_SRC=3.
REQ-035 One sub-module, vga_arb_fifo, parameterized by depth, carrying wr_req_t. It is instantiated three times.

Verification
REQ-036 Single push reg_addr=5, reg_data=0xA5A5A5A5 in cycle 0, wr_ready=1 -> wr_valid in cycle 2, wr_src=0, wr_addr=0x5, wr_data=0xA5A5A5A5, held for one cycle.
REQ-037 All three sources push in the same cycle, wr_ready=1 -> grants reg, instr, data on three consecutive cycles; rr_ptr ends at reg.
REQ-038 wr_ready=0 for 10 cycles with a grant pending -> wr_src/wr_addr/wr_data stable, and instr pushes stop after FIFO_DEPTH entries (instr_ready=0).
REQ-039 Data FIFO filled to 4 entries, push attempted while full -> data_ready=0, no overwrite, and all 4 entries are later emitted in order.
REQ-040 rst pulsed in HOLD with 3 entries buffered -> next cycle wr_valid=0, all x_ready=1, counters 0, and no stale entry emitted.
REQ-041 With VGA_ARB_STATS_EN and CNT_W=2, 5 reg grants -> grant_cnt_reg=3 (saturated). Without the macro -> 0.

Source files
------------

// File: rtl/vga_arb_pkg.sv
// Shared types for the VGA write arbiter: source ids, buffered write request, round-robin helpers.
package vga_arb_pkg;

  localparam int NUM_SRC = 3;

  typedef enum logic [1:0] {
    SRC_REG   = 2'd0,
    SRC_INSTR = 2'd1,
    SRC_DATA  = 2'd2
  } src_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_req_t;

  function automatic src_e rr_next(src_e s);
    return (s == SRC_DATA) ? SRC_REG : src_e'(s + 2'd1);
  endfunction

  // First pending source at or after start, wrapping data -> reg; returns start if none pending.
  function automatic src_e rr_pick(src_e start, logic [NUM_SRC-1:0] pending);
    src_e pick;
    src_e cand;
    logic found;
    pick  = start;
    cand  = start;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && pending[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = rr_next(cand);
    end
    return pick;
  endfunction

endpackage

// File: rtl/vga_arb_fifo.sv
// Per-source write buffer: show-ahead FIFO of wr_req_t, head visible combinationally, push/pop same cycle allowed.
// Full and empty are told apart by one extra pointer bit; a push while full is dropped.
module vga_arb_fifo
  import vga_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wr_req_t push_req,
  input  logic    pop,
  output wr_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  wr_req_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter of reg/instr/data updates onto one display-RAM write port; push-to-wr_valid 2 cycles, one write/cycle.
// Grant stays stable under wr_ready low; x_ready drops only when its FIFO is full. Grant counters exist only with VGA_ARB_STATS_EN.
module vga_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_valid,
  input  logic [4:0]       reg_addr,
  input  logic [31:0]      reg_data,
  output logic             reg_ready,
  input  logic             instr_valid,
  input  logic [31:0]      instr_addr,
  input  logic [31:0]      instr_data,
  output logic             instr_ready,
  input  logic             data_valid,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_data,
  output logic             data_ready,
  output logic             wr_valid,
  output logic [1:0]       wr_src,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  input  logic             wr_ready,
  output logic [CNT_W-1:0] grant_cnt_reg,
  output logic [CNT_W-1:0] grant_cnt_instr,
  output logic [CNT_W-1:0] grant_cnt_data
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e               state;
  state_e               state_nxt;
  src_e                 rr_ptr;
  src_e                 winner;
  src_e                 cur_src;
  wr_req_t              in_req [NUM_SRC];
  wr_req_t              head   [NUM_SRC];
  logic [NUM_SRC-1:0]   valid_in;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   pop;
  logic [NUM_SRC-1:0]   full;
  logic [NUM_SRC-1:0]   empty;
  logic                 any_pending;
  logic                 load;
  logic                 handshake;

  assign in_req[0] = '{addr: 32'(reg_addr), data: reg_data};
  assign in_req[1] = '{addr: instr_addr,    data: instr_data};
  assign in_req[2] = '{addr: data_addr,     data: data_data};

  assign valid_in = {data_valid, instr_valid, reg_valid};
  assign push     = valid_in & ~full;

  // Forced high in reset so upstream never sees a stall caused by pre-reset fill level.
  assign reg_ready   = rst | ~full[0];
  assign instr_ready = rst | ~full[1];
  assign data_ready  = rst | ~full[2];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    vga_arb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[g]),
      .push_req (in_req[g]),
      .pop      (pop[g]),
      .head     (head[g]),
      .full     (full[g]),
      .empty    (empty[g])
    );
  end

  assign any_pending = ~&empty;
  assign wr_valid    = (state == HOLD);
  assign handshake   = wr_valid & wr_ready;
  assign wr_src      = cur_src;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = '0;
    winner    = rr_pick(rr_ptr, ~empty);
    case (state)
      IDLE:    load = any_pending;
      HOLD:    load = wr_ready & any_pending;
      default: load = 1'b0;
    endcase
    if (load) begin
      pop[winner] = 1'b1;
      state_nxt   = HOLD;
    end else if (handshake) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= SRC_REG;
      cur_src <= SRC_REG;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cur_src <= winner;
        wr_addr <= head[winner].addr;
        wr_data <= head[winner].data;
        rr_ptr  <= rr_next(winner);
      end
    end
  end

`ifdef VGA_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt [NUM_SRC];

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '{default: '0};
    end else if (handshake && grant_cnt[cur_src] != {CNT_W{1'b1}}) begin
      grant_cnt[cur_src] <= grant_cnt[cur_src] + 1'b1;
    end
  end

  assign grant_cnt_reg   = grant_cnt[0];
  assign grant_cnt_instr = grant_cnt[1];
  assign grant_cnt_data  = grant_cnt[2];
`else
  assign grant_cnt_reg   = '0;
  assign grant_cnt_instr = '0;
  assign grant_cnt_data  = '0;
`endif

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_vga_write_arbiter;

  localparam int DEPTH  = 4;
  localparam int TB_CNT = 2;
`ifdef VGA_ARB_STATS_EN
  localparam int CNT_MAX = (1 << TB_CNT) - 1;
`else
  localparam int CNT_MAX = 0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              reg_valid, instr_valid, data_valid;
  logic [4:0]        reg_addr;
  logic [31:0]       reg_data, instr_addr, instr_data, data_addr, data_data;
  logic              reg_ready, instr_ready, data_ready;
  logic              wr_valid, wr_ready;
  logic [1:0]        wr_src;
  logic [31:0]       wr_addr, wr_data;
  logic [TB_CNT-1:0] grant_cnt_reg, grant_cnt_instr, grant_cnt_data;

  int n_pass  = 0;
  int n_total = 0;

  vga_write_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (TB_CNT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .reg_valid       (reg_valid),
    .reg_addr        (reg_addr),
    .reg_data        (reg_data),
    .reg_ready       (reg_ready),
    .instr_valid     (instr_valid),
    .instr_addr      (instr_addr),
    .instr_data      (instr_data),
    .instr_ready     (instr_ready),
    .data_valid      (data_valid),
    .data_addr       (data_addr),
    .data_data       (data_data),
    .data_ready      (data_ready),
    .wr_valid        (wr_valid),
    .wr_src          (wr_src),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .grant_cnt_reg   (grant_cnt_reg),
    .grant_cnt_instr (grant_cnt_instr),
    .grant_cnt_data  (grant_cnt_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- reference model (one step per cycle, evaluated mid-cycle) ----------------
  ent_t        mq [3][$];
  bit          m_valid = 1'b0;
  logic [1:0]  m_src   = 2'd0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_data  = '0;
  int          m_rr    = 0;
  int          m_cnt [3] = '{0, 0, 0};
  bit          acc [3];
  bit          vin [3];
  ent_t        ein [3];
  bit          hs, found;
  int          s;

  always @(negedge clk) begin
    chk("model wr_valid", 32'(wr_valid), 32'(m_valid));
    if (m_valid) begin
      chk("model wr_src",  32'(wr_src), 32'(m_src));
      chk("model wr_addr", wr_addr, m_addr);
      chk("model wr_data", wr_data, m_data);
    end
    chk("model reg_ready",   32'(reg_ready),   32'(rst || mq[0].size() < DEPTH));
    chk("model instr_ready", 32'(instr_ready), 32'(rst || mq[1].size() < DEPTH));
    chk("model data_ready",  32'(data_ready),  32'(rst || mq[2].size() < DEPTH));
    chk("model cnt_reg",   32'(grant_cnt_reg),   m_cnt[0]);
    chk("model cnt_instr", 32'(grant_cnt_instr), m_cnt[1]);
    chk("model cnt_data",  32'(grant_cnt_data),  m_cnt[2]);

    vin[0] = reg_valid; vin[1] = instr_valid; vin[2] = data_valid;
    ein[0] = '{32'(reg_addr), reg_data};
    ein[1] = '{instr_addr, instr_data};
    ein[2] = '{data_addr, data_data};
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mq[k].delete();
        m_cnt[k] = 0;
      end
      m_valid = 1'b0; m_src = 2'd0; m_addr = '0; m_data = '0; m_rr = 0;
    end else begin
      // A source that is full at the start of the cycle refuses the push even if it is popped.
      for (int k = 0; k < 3; k++) acc[k] = vin[k] && (mq[k].size() < DEPTH);
      hs = m_valid && wr_ready;
      if (hs && m_cnt[m_src] < CNT_MAX) m_cnt[m_src]++;
      if (!m_valid || hs) begin
        found = 1'b0;
        for (int j = 0; j < 3; j++) begin
          s = (m_rr + j) % 3;
          if (!found && mq[s].size() > 0) begin
            found  = 1'b1;
            m_src  = 2'(s);
            m_addr = mq[s][0].addr;
            m_data = mq[s][0].data;
            void'(mq[s].pop_front());
            m_rr   = (s + 1) % 3;
          end
        end
        m_valid = found;
      end
      for (int k = 0; k < 3; k++) if (acc[k]) mq[k].push_back(ein[k]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_in();
    reg_valid = 1'b0; instr_valid = 1'b0; data_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [31:0] got [$];

  initial begin
    rst = 1'b1; wr_ready = 1'b0; idle_in();
    reg_addr = '0; reg_data = '0; instr_addr = '0; instr_data = '0; data_addr = '0; data_data = '0;
    step(); step();
    rst = 1'b0;
    mid();
    chk("reset wr_valid", 32'(wr_valid), 32'd0);
    chk("reset wr_src",   32'(wr_src),   32'd0);
    chk("reset wr_addr",  wr_addr,       32'd0);
    chk("reset wr_data",  wr_data,       32'd0);
    chk("reset readies",  32'({reg_ready, instr_ready, data_ready}), 32'h7);
    chk("reset counters", 32'({grant_cnt_reg, grant_cnt_instr, grant_cnt_data}), 32'd0);

    // single reg push: visible two cycles later for exactly one cycle
    step();
    reg_valid = 1'b1; reg_addr = 5'd5; reg_data = 32'hA5A5_A5A5; wr_ready = 1'b1;
    step(); reg_valid = 1'b0;
    mid(); chk("single c1 wr_valid", 32'(wr_valid), 32'd0);
    step();
    mid();
    chk("single c2 wr_valid", 32'(wr_valid), 32'd1);
    chk("single c2 wr_src",   32'(wr_src),   32'd0);
    chk("single c2 wr_addr",  wr_addr,       32'h5);
    chk("single c2 wr_data",  wr_data,       32'hA5A5_A5A5);
    step();
    mid(); chk("single c3 wr_valid", 32'(wr_valid), 32'd0);

    // three simultaneous pushes: reg, instr, data back to back
    step(); do_reset();
    reg_valid = 1'b1; reg_addr = 5'd1; reg_data = 32'h11;
    instr_valid = 1'b1; instr_addr = 32'h1000; instr_data = 32'h22;
    data_valid = 1'b1; data_addr = 32'h2000; data_data = 32'h33;
    step(); idle_in();
    step(); mid(); chk("rr g0 src", 32'(wr_src), 32'd0); chk("rr g0 addr", wr_addr, 32'h1);
    step(); mid(); chk("rr g1 src", 32'(wr_src), 32'd1); chk("rr g1 addr", wr_addr, 32'h1000);
    step(); mid(); chk("rr g2 src", 32'(wr_src), 32'd2); chk("rr g2 addr", wr_addr, 32'h2000);
    step(); mid(); chk("rr drained", 32'(wr_valid), 32'd0);
    // pointer back at reg: the next three-way contest is again won by reg
    reg_valid = 1'b1; instr_valid = 1'b1; data_valid = 1'b1;
    step(); idle_in();
    step(); mid(); chk("rr wrap src", 32'(wr_src), 32'd0);
    step(); step(); step();

    // stalled grant with instr pushes continuing
    do_reset();
    wr_ready = 1'b0;
    reg_valid = 1'b1; reg_addr = 5'd7; reg_data = 32'h77;
    step(); reg_valid = 1'b0; instr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr_addr = 32'd100 + 32'(i); instr_data = 32'hB0 + 32'(i);
      mid();
      if (i >= 1) begin
        chk("stall wr_addr", wr_addr, 32'h7);
        chk("stall wr_data", wr_data, 32'h77);
      end
      step();
    end
    mid(); chk("stall instr_ready", 32'(instr_ready), 32'd0);
    step(); idle_in(); wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // data FIFO full: extra push refused, buffered entries emitted in order
    do_reset();
    wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_valid = 1'b1; data_addr = 32'h200 + 32'(i); data_data = 32'hD0 + 32'(i);
      mid();
      if (i == 5) chk("full data_ready", 32'(data_ready), 32'd0);
      step();
    end
    idle_in(); wr_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 12; i++) begin
      mid();
      if (wr_valid) got.push_back(wr_addr);
      step();
    end
    chk("full emitted count", 32'(got.size()), 32'd5);
    for (int k = 0; k < 5; k++) chk("full emitted order", got[k], 32'h200 + 32'(k));

    // reset while holding a grant with three entries buffered
    do_reset();
    wr_ready = 1'b0;
    reg_valid = 1'b1; reg_addr = 5'h11;
    instr_valid = 1'b1; instr_addr = 32'h32;
    data_valid = 1'b1; data_addr = 32'h33;
    step(); idle_in(); reg_valid = 1'b1; reg_addr = 5'h14;
    step(); idle_in();
    step(); mid(); chk("rstq pre wr_valid", 32'(wr_valid), 32'd1);
    step(); rst = 1'b1;
    mid(); chk("rstq during readies", 32'({reg_ready, instr_ready, data_ready}), 32'h7);
    step(); rst = 1'b0; wr_ready = 1'b1;
    mid();
    chk("rstq after wr_valid", 32'(wr_valid), 32'd0);
    chk("rstq after readies",  32'({reg_ready, instr_ready, data_ready}), 32'h7);
    chk("rstq after counters", 32'({grant_cnt_reg, grant_cnt_instr, grant_cnt_data}), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(); mid(); chk("rstq no stale", 32'(wr_valid), 32'd0);
    end

    // five reg grants against a 2-bit counter
    step(); do_reset();
    wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reg_valid = 1'b1; reg_addr = 5'(i); reg_data = 32'(i);
      step();
    end
    idle_in();
    for (int i = 0; i < 4; i++) step();
    mid();
    chk("cnt reg sat",  32'(grant_cnt_reg),   32'(CNT_MAX));
    chk("cnt instr",    32'(grant_cnt_instr), 32'd0);
    chk("cnt data",     32'(grant_cnt_data),  32'd0);

    // mixed traffic with periodic backpressure, checked by the model
    step(); do_reset();
    for (int i = 0; i < 48; i++) begin
      reg_valid   = (i % 3 == 0); reg_addr = 5'(i);           reg_data   = 32'h1000_0000 + 32'(i);
      instr_valid = (i % 2 == 0); instr_addr = 32'h4000 + 32'(i); instr_data = 32'h2000_0000 + 32'(i);
      data_valid  = (i % 5 != 4); data_addr = 32'h8000 + 32'(i);  data_data  = 32'h3000_0000 + 32'(i);
      wr_ready    = (i % 4 != 3);
      step();
    end
    idle_in(); wr_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    mid(); chk("mixed drained", 32'(wr_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
